// File: rtl/perceptron_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_ctrl
// Purpose  : Sequencer for a perceptron-style classifier. Holds N_INPUTS
//            signed weights plus a bias. Evaluates one input vector with a
//            single shared multiply-accumulate, one term per cycle. On a
//            misclassification it can apply the perceptron learning rule,
//            again one element per cycle.
// Ports    : clk, rst_n         clock, async active-low reset
//            cfg_we/addr/wdata  weight (addr 0..N-1) / bias (addr N) write
//            rd_addr, rd_data   combinational readback, same address map
//            start, x_vec       evaluation request and input vector
//            label, train_en    desired class and learning enable
//            busy, done         status, done is a one-cycle pulse
//            classification     registered result of the last evaluation
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_ctrl #(
  parameter int N_INPUTS = 4,
  parameter int X_WIDTH  = 4,
  parameter int W_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(N_INPUTS+1)-1:0] cfg_addr,
  input  logic [W_WIDTH-1:0]            cfg_wdata,
  input  logic [$clog2(N_INPUTS+1)-1:0] rd_addr,
  output logic [W_WIDTH-1:0]            rd_data,
  input  logic                          start,
  input  logic [N_INPUTS*X_WIDTH-1:0]   x_vec,
  input  logic                          label,
  input  logic                          train_en,
  output logic                          busy,
  output logic                          done,
  output logic                          classification
);

  localparam int AW     = $clog2(N_INPUTS+1);
  localparam int KW     = $clog2(N_INPUTS);
  localparam int ACC_W  = W_WIDTH + X_WIDTH + $clog2(N_INPUTS) + 1;
  localparam int PROD_W = W_WIDTH + X_WIDTH + 1;
  localparam int SUM_W  = W_WIDTH + X_WIDTH + 1;

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_accum  = 3'd1;
  localparam logic [2:0] c_decide = 3'd2;
  localparam logic [2:0] c_update = 3'd3;
  localparam logic [2:0] c_done   = 3'd4;

  // Saturation limits of a weight, expressed at the wider update-sum width.
  localparam logic signed [SUM_W-1:0] c_sat_max =
    {{(SUM_W-W_WIDTH+1){1'b0}}, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] c_sat_min =
    {{(SUM_W-W_WIDTH+1){1'b1}}, {(W_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] c_one = {{(SUM_W-1){1'b0}}, 1'b1};

  function automatic logic signed [W_WIDTH-1:0] f_sat(input logic signed [SUM_W-1:0] s);
    if (s > c_sat_max)      return c_sat_max[W_WIDTH-1:0];
    else if (s < c_sat_min) return c_sat_min[W_WIDTH-1:0];
    else                    return s[W_WIDTH-1:0];
  endfunction

  logic [2:0]                   r_state;
  logic [KW-1:0]                r_k;
  logic signed [ACC_W-1:0]      r_acc;
  logic [N_INPUTS*X_WIDTH-1:0]  r_x;
  logic                         r_label;
  logic                         r_train;
  logic                         r_class;
  logic signed [W_WIDTH-1:0]    r_w [N_INPUTS];
  logic signed [W_WIDTH-1:0]    r_bias;

  logic                         w_last;
  logic                         w_cfg_ok;
  logic                         w_cfg_bias;
  logic                         w_pos;
  logic [X_WIDTH-1:0]           w_xk;
  logic signed [W_WIDTH-1:0]    w_wk;
  logic signed [PROD_W-1:0]     w_wk_p;
  logic signed [PROD_W-1:0]     w_xk_p;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_acc_next;
  logic signed [W_WIDTH-1:0]    w_bias_eff;
  logic signed [SUM_W-1:0]      w_wk_s;
  logic signed [SUM_W-1:0]      w_xk_s;
  logic signed [SUM_W-1:0]      w_b_s;
  logic signed [W_WIDTH-1:0]    w_upd;
  logic signed [W_WIDTH-1:0]    w_bias_upd;

  assign w_last     = (r_k == KW'(N_INPUTS-1));
  assign w_cfg_ok   = (r_state == c_idle) && cfg_we;
  assign w_cfg_bias = w_cfg_ok && (cfg_addr == AW'(N_INPUTS));
  // acc == 0 counts as class 0, so "positive" means non-negative and non-zero.
  assign w_pos      = !r_acc[ACC_W-1] && (r_acc != '0);

  assign w_xk   = r_x[r_k*X_WIDTH +: X_WIDTH];
  assign w_wk   = r_w[r_k];

  // Inputs are unsigned: zero-extend x, sign-extend w, multiply at full width.
  assign w_wk_p     = {{(PROD_W-W_WIDTH){w_wk[W_WIDTH-1]}}, w_wk};
  assign w_xk_p     = {{(PROD_W-X_WIDTH){1'b0}}, w_xk};
  assign w_prod     = w_wk_p * w_xk_p;
  assign w_acc_next = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // A bias written on the same edge as start must seed the accumulator.
  assign w_bias_eff = w_cfg_bias ? cfg_wdata : r_bias;

  assign w_wk_s     = {{(SUM_W-W_WIDTH){w_wk[W_WIDTH-1]}}, w_wk};
  assign w_xk_s     = {{(SUM_W-X_WIDTH){1'b0}}, w_xk};
  assign w_b_s      = {{(SUM_W-W_WIDTH){r_bias[W_WIDTH-1]}}, r_bias};
  assign w_upd      = f_sat(r_label ? (w_wk_s + w_xk_s) : (w_wk_s - w_xk_s));
  assign w_bias_upd = f_sat(r_label ? (w_b_s + c_one) : (w_b_s - c_one));

  // Control sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_k     <= '0;
      r_acc   <= '0;
      r_x     <= '0;
      r_label <= 1'b0;
      r_train <= 1'b0;
      r_class <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_x     <= x_vec;
            r_label <= label;
            r_train <= train_en;
            r_acc   <= {{(ACC_W-W_WIDTH){w_bias_eff[W_WIDTH-1]}}, w_bias_eff};
            r_k     <= '0;
            r_state <= c_accum;
          end
        end
        c_accum: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_k     <= '0;
            r_state <= c_decide;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        c_decide: begin
          r_class <= w_pos;
          r_state <= (r_train && (r_label != w_pos)) ? c_update : c_done;
        end
        c_update: begin
          if (w_last) begin
            r_k     <= '0;
            r_state <= c_done;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  // Weight and bias storage: configuration writes only in IDLE, learning
  // updates only in UPDATE, so the two sources never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) r_w[i] <= '0;
      r_bias <= '0;
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (w_cfg_ok && (cfg_addr == AW'(i)))
          r_w[i] <= cfg_wdata;
        else if ((r_state == c_update) && (r_k == KW'(i)))
          r_w[i] <= w_upd;
      end
      if (w_cfg_bias)
        r_bias <= cfg_wdata;
      else if ((r_state == c_update) && (r_k == '0))
        r_bias <= w_bias_upd;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr == AW'(N_INPUTS)) rd_data = r_bias;
    for (int i = 0; i < N_INPUTS; i++)
      if (rd_addr == AW'(i)) rd_data = r_w[i];
  end

  assign busy           = (r_state != c_idle);
  assign done           = (r_state == c_done);
  assign classification = r_class;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_perceptron_ctrl
// Purpose  : Self-checking bench for perceptron_ctrl (N=4, X=4, W=4).
//            Issued evaluations push expected class/latency into a queue;
//            a monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perceptron_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [3:0]  cfg_wdata;
  logic [2:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        start;
  logic [15:0] x_vec;
  logic        label;
  logic        train_en;
  logic        busy;
  logic        done;
  logic        classification;

  perceptron_ctrl #(.N_INPUTS(4), .X_WIDTH(4), .W_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .rd_addr(rd_addr), .rd_data(rd_data),
    .start(start), .x_vec(x_vec), .label(label), .train_en(train_en),
    .busy(busy), .done(done), .classification(classification)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic  cls;
    int    lat;
    int    acc;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor: latency counts the accept edge as cycle 1 up to the edge that
  // samples done high.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_class"}, int'(classification), int'(e.cls));
        chk({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
      end
    end
  end

  function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
    return {d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int v);
    cfg_we    = 1'b1;
    cfg_addr  = a[2:0];
    cfg_wdata = v[3:0];
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic load(input int w0, input int w1, input int w2, input int w3, input int b);
    wr(0, w0); wr(1, w1); wr(2, w2); wr(3, w3); wr(4, b);
  endtask

  task automatic rd_chk(input string nm, input int a, input int exp);
    rd_addr = a[2:0];
    #1;
    chk(nm, int'($signed(rd_data)), exp);
  endtask

  task automatic go(input string nm, input logic [15:0] xv, input logic lbl,
                    input logic tr, input logic ecls, input int elat);
    exp_t e;
    x_vec    = xv;
    label    = lbl;
    train_en = tr;
    start    = 1'b1;
    e.cls = ecls; e.lat = elat; e.acc = cyc + 1; e.name = nm;
    sb_q.push_back(e);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, int'(n >= 60), 0);
    sb_q.delete();
  endtask

  task automatic abort_check(input string nm);
    int d0;
    sb_q.delete();
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_class"}, int'(classification), 0);
    for (int a = 0; a < 5; a++) rd_chk({nm, "_rd"}, a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick();
    chk({nm, "_no_done"}, done_cnt - d0, 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; rd_addr = '0;
    start = 1'b0; x_vec = '0; label = 1'b0; train_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_class", int'(classification), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) rd_chk("rst_rd", a, 0);

    // 1: zero weights -> acc 0 -> class 0
    go("t1", pk(15, 15, 15, 15), 1'b0, 1'b0, 1'b0, 6);
    wait_idle("t1");

    // 2: acc = -1 + 3 + 2 - 6 + 0 = -2
    load(1, 2, -3, 0, -1);
    go("t2", pk(3, 1, 2, 5), 1'b0, 1'b0, 1'b0, 6);
    wait_idle("t2");
    rd_chk("t2_w0", 0, 1);  rd_chk("t2_w1", 1, 2);  rd_chk("t2_w2", 2, -3);
    rd_chk("t2_w3", 3, 0);  rd_chk("t2_b", 4, -1);

    // 3: label 1 misclassified -> w += x, bias += 1
    go("t3", pk(3, 1, 2, 5), 1'b1, 1'b1, 1'b0, 10);
    wait_idle("t3");
    rd_chk("t3_w0", 0, 4);  rd_chk("t3_w1", 1, 3);  rd_chk("t3_w2", 2, -1);
    rd_chk("t3_w3", 3, 5);  rd_chk("t3_b", 4, 0);
    go("t3_rerun", pk(3, 1, 2, 5), 1'b0, 1'b0, 1'b1, 6);
    wait_idle("t3_rerun");

    // 4a: acc = 105 - 360 < 0, label 1 -> w0 clamps at 7
    load(7, -8, -8, -8, 0);
    go("t4a", pk(15, 15, 15, 15), 1'b1, 1'b1, 1'b0, 10);
    wait_idle("t4a");
    rd_chk("t4a_w0", 0, 7);  rd_chk("t4a_w1", 1, 7);  rd_chk("t4a_b", 4, 1);

    // 4b: acc = -8 + 105 - 24 > 0, label 0 -> w1 and bias clamp at -8
    load(7, -8, 0, 0, -8);
    go("t4b", pk(15, 3, 0, 0), 1'b0, 1'b1, 1'b1, 10);
    wait_idle("t4b");
    rd_chk("t4b_w0", 0, -8);  rd_chk("t4b_w1", 1, -8);  rd_chk("t4b_b", 4, -8);

    // 5a: start and cfg_we during ACCUM are ignored
    load(1, 0, 0, 0, 0);
    d0 = done_cnt;
    go("t5a", pk(1, 0, 0, 0), 1'b0, 1'b0, 1'b1, 6);
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 4'd5;
    tick(); tick();
    start = 1'b0; cfg_we = 1'b0;
    wait_idle("t5a");
    repeat (8) tick();
    chk("t5a_done_pulses", done_cnt - d0, 1);
    rd_chk("t5a_w0", 0, 1);

    // 5b: w0 := -1 on the start edge -> acc = -1 -> class 0
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 4'hF;
    go("t5b", pk(1, 0, 0, 0), 1'b0, 1'b0, 1'b0, 6);
    cfg_we = 1'b0;
    wait_idle("t5b");

    // 5c: bias := 3 on the start edge -> acc = 3 - 1 = 2 -> class 1
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 4'd3;
    go("t5c", pk(1, 0, 0, 0), 1'b0, 1'b0, 1'b1, 6);
    cfg_we = 1'b0;
    wait_idle("t5c");
    rd_chk("t5c_b", 4, 3);

    // 6a: reset in the middle of ACCUM
    chk("t6a_class_pre", int'(classification), 1);
    go("t6a", pk(1, 0, 0, 0), 1'b0, 1'b0, 1'b1, 6);
    tick();
    abort_check("t6a");

    // 6b: reset in the middle of UPDATE (class 1, label 0 -> update)
    load(1, 0, 0, 0, 0);
    go("t6b", pk(1, 0, 0, 0), 1'b0, 1'b1, 1'b1, 10);
    repeat (6) tick();
    chk("t6b_busy_pre", int'(busy), 1);
    chk("t6b_class_pre", int'(classification), 1);
    abort_check("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
